ifu_fetch: RTL and testbench

//   Instruction fetch unit: owns the PC and issues one request at a time to instruction memory.

---
 rtl/ifu_fetch_if.sv | 27 ++
 rtl/ifu_fetch.sv | 107 ++++++++++
 tb/tb_ifu_fetch.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Instruction-memory channel between the fetch unit (master) and imem (slave):
// a valid/ready request carrying the fetch address and a one-beat response.
interface ifu_fetch_if;
  localparam int unsigned XLEN = 32;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, keeps at most one imem request in flight,
// presents fetched words to IF/ID and squashes fetches made stale by EX redirects.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_fetch_if.master imem,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        inst_valid_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] inst_o
);
  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2,
    KILL = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            req_valid;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pc_seq;
  logic            req_fire;
  logic            unused_redirect_lsb;

  // Instructions are word aligned, so the low target bits are dropped.
  assign redirect_tgt        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign pc_seq              = pc + XLEN'(4);
  assign req_fire            = req_valid & imem.req_ready;

  assign imem.req_valid = req_valid;
  assign imem.req_addr  = pc;

  // req_valid is a flop that resets low, so the first REQ cycle after reset only raises it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= REQ;
      pc           <= RESET_PC;
      req_valid    <= 1'b0;
      inst_valid_o <= 1'b0;
      inst_addr_o  <= '0;
      inst_o       <= INST_NOP;
    end else begin
      case (state)
        REQ: begin
          req_valid <= 1'b1;
          if (redirect_valid) pc <= redirect_tgt;
          // A redirect racing the handshake leaves the old fetch in flight; KILL eats its response.
          if (req_fire) begin
            req_valid <= 1'b0;
            state     <= redirect_valid ? KILL : WAIT;
          end
        end

        WAIT: begin
          if (redirect_valid) begin
            pc    <= redirect_tgt;
            state <= KILL;
          end else if (imem.rsp_valid) begin
            inst_o       <= imem.rsp_data;
            inst_addr_o  <= pc;
            inst_valid_o <= 1'b1;
            state        <= OUT;
          end
        end

        OUT: begin
          if (redirect_valid) begin
            inst_valid_o <= 1'b0;
            inst_o       <= INST_NOP;
            pc           <= redirect_tgt;
            req_valid    <= 1'b1;
            state        <= REQ;
          end else if (id_ready) begin
            inst_valid_o <= 1'b0;
            inst_o       <= INST_NOP;
            pc           <= pc_seq;
            req_valid    <= 1'b1;
            state        <= REQ;
          end
        end

        KILL: begin
          if (redirect_valid) pc <= redirect_tgt;
          if (imem.rsp_valid) begin
            req_valid <= 1'b1;
            state     <= REQ;
          end
        end

        default: begin
          req_valid <= 1'b0;
          state     <= REQ;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: directed redirect/stall/reset scenarios against
// an imem model with programmable response latency.
module tb_ifu_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        inst_valid_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_o;

  ifu_fetch_if imem();

  ifu_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .inst_valid_o   (inst_valid_o),
    .inst_addr_o    (inst_addr_o),
    .inst_o         (inst_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  int unsigned tick = 0;

  logic [31:0] exp_req_q[$];
  out_t        exp_out_q[$];
  int unsigned pend_due_q[$];
  logic [31:0] pend_data_q[$];

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] dat(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input logic [31:0] a);
    exp_req_q.push_back(a);
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_req_q.push_back(a);
    exp_out_q.push_back({a, dat(a)});
  endtask

  task automatic accept_reqs();
    int n = 0;
    imem.req_ready = 1'b1;
    while (exp_req_q.size() != 0 && n < 200) begin
      cyc(1);
      n++;
    end
    imem.req_ready = 1'b0;
    check("req_timeout", 32'(exp_req_q.size()), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    accept_reqs();
    while (exp_out_q.size() != 0 && n < 200) begin
      cyc(1);
      n++;
    end
    check("out_timeout", 32'(exp_out_q.size()), 32'd0);
  endtask

  // imem model: handshake seen before the edge, response driven lat cycles later.
  initial begin
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (imem.req_valid && imem.req_ready) begin
        if (exp_req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected actual=%h required=none", imem.req_addr);
        end else begin
          check("req_addr", imem.req_addr, exp_req_q.pop_front());
        end
        pend_due_q.push_back(tick + mem_lat);
        pend_data_q.push_back(dat(imem.req_addr));
      end
      @(posedge clk);
      #1;
      tick++;
      if (pend_due_q.size() != 0 && pend_due_q[0] <= tick) begin
        void'(pend_due_q.pop_front());
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = pend_data_q.pop_front();
      end else begin
        imem.rsp_valid = 1'b0;
        imem.rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Output monitor: every accepted instruction must match the next expected fetch.
  always @(negedge clk) begin : monitor
    out_t e;
    if (inst_valid_o && id_ready && !redirect_valid) begin
      if (exp_out_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected actual=%h/%h required=none", inst_addr_o, inst_o);
      end else begin
        e = exp_out_q.pop_front();
        check("out_addr", inst_addr_o, e.addr);
        check("out_data", inst_o, e.data);
      end
    end
    if (!inst_valid_o) check("idle_nop", inst_o, NOP);
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;
    imem.req_ready = 1'b0;
    cyc(3);
    @(negedge clk);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_inst", inst_o, NOP);
    check("rst_addr", inst_addr_o, 32'd0);
    check("rst_req_valid", 32'(imem.req_valid), 32'd0);
    check("rst_pc", imem.req_addr, 32'h8000_0000);
    cyc(1);
    rst_n = 1'b1;

    // Sequential fetch from the reset PC.
    expect_fetch(32'h8000_0000);
    expect_fetch(32'h8000_0004);
    expect_fetch(32'h8000_0008);
    drain();

    // IF/ID stall while an instruction is presented.
    id_ready = 1'b0;
    expect_fetch(32'h8000_000C);
    accept_reqs();
    n = 0;
    while (!inst_valid_o && n < 50) begin
      cyc(1);
      n++;
    end
    check("stall_valid_seen", 32'(inst_valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(inst_valid_o), 32'd1);
      check("stall_addr", inst_addr_o, 32'h8000_000C);
      check("stall_data", inst_o, dat(32'h8000_000C));
      check("stall_no_req", 32'(imem.req_valid), 32'd0);
    end
    cyc(1);
    id_ready = 1'b1;
    expect_fetch(32'h8000_0010);
    drain();

    // Redirect while waiting; the stale response lands two cycles later.
    mem_lat = 3;
    expect_req(32'h8000_0014);
    accept_reqs();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("kill_no_req", 32'(imem.req_valid), 32'd0);
    check("kill_pc", imem.req_addr, 32'h8000_0100);
    cyc(1);
    mem_lat = 1;
    expect_fetch(32'h8000_0100);
    drain();

    // Redirect in the same cycle as the request handshake.
    expect_req(32'h8000_0104);
    expect_fetch(32'h8000_0200);
    imem.req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    cyc(1);
    redirect_valid = 1'b0;
    drain();

    // Redirect while the request is still unaccepted.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    cyc(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("retarget_valid", 32'(imem.req_valid), 32'd1);
    check("retarget_addr", imem.req_addr, 32'h8000_0300);
    cyc(1);
    expect_fetch(32'h8000_0300);
    drain();

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    cyc(1);
    redirect_valid = 1'b0;
    expect_fetch(32'hFFFF_FFFC);
    expect_fetch(32'h0000_0000);
    drain();

    // Reset pulse while a fetch is outstanding; its response arrives after release.
    mem_lat = 3;
    expect_req(32'h0000_0004);
    accept_reqs();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(inst_valid_o), 32'd0);
    check("mid_rst_inst", inst_o, NOP);
    check("mid_rst_addr", inst_addr_o, 32'd0);
    check("mid_rst_req_valid", 32'(imem.req_valid), 32'd0);
    cyc(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_pc", imem.req_addr, 32'h8000_0000);
    cyc(4);
    mem_lat = 1;
    expect_fetch(32'h8000_0000);
    drain();

    cyc(3);
    check("pending_rsp_left", 32'(pend_due_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
